// File: rtl/g_word_serializer.sv
// Captures one wide 4-state word per handshake, scrubs X/Z to 0 and streams it as OUT_W-bit beats, LSB beat first.
// Define G_WORD_SERIALIZER_PARITY_EN to append an XOR parity beat after the data beats.
module g_word_serializer #(
    parameter int unsigned IN_W  = 96,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_xz,
    output logic             out_last,
    output logic             out_tag,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             busy
);
    localparam int unsigned BEATS = IN_W / OUT_W;
    localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    if (((IN_W % OUT_W) != 0) || (BEATS == 0)) begin : g_bad_width
        $error("g_word_serializer: IN_W must be a nonzero multiple of OUT_W");
    end

`ifdef G_WORD_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SEND, PAR} state_t;
    localparam logic FIRST_IS_LAST = 1'b0;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
    localparam logic FIRST_IS_LAST = (BEATS == 1);
`endif

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  nxt_idx;
    logic [IN_W-1:0]   word_q;
    logic [BEATS-1:0]  xz_q;

    logic              vld;
    logic              rdy;
    logic              final_beat;
    logic              in_hs;
    logic              out_hs;

    logic [IN_W-1:0]   scrub_word;
    logic [IN_W-1:0]   xz_bits;
    logic [BEATS-1:0]  scrub_xz;
    logic              scrub_tag;

    // Only an explicit 1 counts as asserted; X/Z reads as 0.
    function automatic logic is_one(input logic b);
        logic r;
        case (b)
            1'b1:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign vld = is_one(in_valid);
    assign rdy = is_one(out_ready);

`ifdef G_WORD_SERIALIZER_PARITY_EN
    assign final_beat = (state == PAR);
`else
    assign final_beat = (state == SEND) && (idx == LAST_IDX);
`endif

    // Accepting during the final beat lets the next word follow with no bubble.
    assign in_ready = (state == IDLE) || (final_beat && rdy);
    assign in_hs    = vld && in_ready;
    assign out_hs   = out_valid && rdy;
    assign busy     = (state != IDLE);
    assign nxt_idx  = idx + IDX_W'(1);

    always_comb begin
        scrub_word = '0;
        xz_bits    = '0;
        scrub_xz   = '0;
        for (int i = 0; i < IN_W; i++) begin
            case (in_data[i])
                1'b1:    scrub_word[i] = 1'b1;
                1'b0:    ;
                default: xz_bits[i] = 1'b1;
            endcase
        end
        for (int b = 0; b < BEATS; b++) begin
            scrub_xz[b] = |xz_bits[b*OUT_W +: OUT_W];
        end
        scrub_tag = is_one(in_tag);
    end

`ifdef G_WORD_SERIALIZER_PARITY_EN
    logic [OUT_W-1:0] par_data;

    // out_tag already holds the scrubbed tag for the whole word.
    always_comb begin
        par_data = '0;
        for (int b = 0; b < BEATS; b++) begin
            par_data = par_data ^ word_q[b*OUT_W +: OUT_W];
        end
        par_data[0] = par_data[0] ^ out_tag;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            word_q    <= '0;
            xz_q      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_xz    <= 1'b0;
            out_last  <= 1'b0;
            out_tag   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (in_hs) begin
                state     <= SEND;
                idx       <= '0;
                word_q    <= scrub_word;
                xz_q      <= scrub_xz;
                out_valid <= 1'b1;
                out_data  <= scrub_word[OUT_W-1:0];
                out_xz    <= scrub_xz[0];
                out_last  <= FIRST_IS_LAST;
                out_tag   <= scrub_tag;
            end else if (out_hs) begin
                case (state)
                    SEND: begin
                        if (idx != LAST_IDX) begin
                            idx      <= nxt_idx;
                            out_data <= word_q[nxt_idx*OUT_W +: OUT_W];
                            out_xz   <= xz_q[nxt_idx];
`ifdef G_WORD_SERIALIZER_PARITY_EN
                            out_last <= 1'b0;
`else
                            out_last <= (nxt_idx == LAST_IDX);
`endif
                        end else begin
`ifdef G_WORD_SERIALIZER_PARITY_EN
                            state    <= PAR;
                            out_data <= par_data;
                            out_xz   <= |xz_q;
                            out_last <= 1'b1;
`else
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
`endif
                        end
                    end
`ifdef G_WORD_SERIALIZER_PARITY_EN
                    PAR: begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
`endif
                    default: ;
                endcase
            end

            if (out_hs && final_beat) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_g_word_serializer.sv
// Directed self-checking bench for g_word_serializer (default build, or with G_WORD_SERIALIZER_PARITY_EN).
module tb_g_word_serializer;
    localparam int unsigned IN_W  = 96;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned CNT_W = 8;
    localparam int BEATS = 6;
`ifdef G_WORD_SERIALIZER_PARITY_EN
    localparam int TOT = BEATS + 1;
`else
    localparam int TOT = BEATS;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_xz;
    logic             out_last;
    logic             out_tag;
    logic [CNT_W-1:0] frame_cnt;
    logic             busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    g_word_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_xz(out_xz), .out_last(out_last), .out_tag(out_tag),
        .frame_cnt(frame_cnt), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic is_xz(input logic b);
        return (b !== 1'b0) && (b !== 1'b1);
    endfunction

    // Expected {xz, data} for beat k, derived from the value the bench actually drives.
    function automatic logic [16:0] exp_beat(input logic [IN_W-1:0] w, input logic tg, input int k);
        logic [15:0] d;
        logic        xz;
        d  = '0;
        xz = 1'b0;
        if (k < BEATS) begin
            for (int i = 0; i < OUT_W; i++) begin
                d[i] = (w[k*OUT_W+i] === 1'b1);
                if (is_xz(w[k*OUT_W+i])) xz = 1'b1;
            end
        end else begin
            for (int j = 0; j < BEATS; j++) begin
                for (int i = 0; i < OUT_W; i++) begin
                    d[i] = d[i] ^ (w[j*OUT_W+i] === 1'b1);
                    if (is_xz(w[j*OUT_W+i])) xz = 1'b1;
                end
            end
            d[0] = d[0] ^ (tg === 1'b1);
        end
        return {xz, d};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Offers one word from IDLE, then drains it with out_ready following pat (bit c%4 in cycle c).
    task automatic recv_word(input logic [IN_W-1:0] w, input logic tg, input logic [3:0] pat,
                             input string nm, output logic [15:0] last_data);
        int          nb;
        logic [16:0] e;
        nb = 0;
        last_data = '0;
        in_data = w; in_tag = tg; in_valid = 1'b1; out_ready = pat[0];
        @(negedge clk);
        in_valid = 1'b0;
        check({nm, "_lat"}, 32'(out_valid), 32'(1));
        for (int cyc = 0; cyc < 64 && nb < TOT; cyc++) begin
            out_ready = pat[2'(cyc % 4)];
            if (out_valid) begin
                e = exp_beat(w, tg, nb);
                check({nm, "_data"}, 32'(out_data), 32'(e[15:0]));
                check({nm, "_xz"}, 32'(out_xz), 32'(e[16]));
                check({nm, "_last"}, 32'(out_last), 32'(nb == TOT - 1));
                check({nm, "_tag"}, 32'(out_tag), 32'(tg === 1'b1));
                if (out_ready) begin
                    last_data = out_data;
                    nb++;
                end
            end
            @(negedge clk);
        end
        check({nm, "_beats"}, 32'(nb), 32'(TOT));
        check({nm, "_idle"}, 32'(out_valid), 32'(0));
        out_ready = 1'b0;
    endtask

    logic [IN_W-1:0] w, wa, wb, wx;
    logic [15:0]     ld;
    logic [16:0]     e;
    int              lasts, vcyc;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_xz", 32'(out_xz), 32'(0));
        check("rst_out_last", 32'(out_last), 32'(0));
        check("rst_out_tag", 32'(out_tag), 32'(0));
        check("rst_frame_cnt", 32'(frame_cnt), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Single word, no backpressure.
        w = 96'h0005_0004_0003_0002_0001_0000;
        recv_word(w, 1'b1, 4'b1111, "t1", ld);
`ifndef G_WORD_SERIALIZER_PARITY_EN
        check("t1_final_beat", 32'(ld), 32'h0005);
`endif
        check("t1_frames", 32'(frame_cnt), 32'(1));

        // Two words back to back: no bubble, in_ready only on final beats.
        do_reset();
        wa = 96'h0015_0014_0013_0012_0011_0010;
        wb = 96'h0025_0024_0023_0022_0021_0020;
        in_data = wa; in_tag = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_data = wb; in_tag = 1'b0;
        for (int k = 0; k < 2 * TOT; k++) begin
            e = exp_beat((k < TOT) ? wa : wb, (k < TOT), k % TOT);
            check("t2_valid", 32'(out_valid), 32'(1));
            check("t2_data", 32'(out_data), 32'(e[15:0]));
            check("t2_tag", 32'(out_tag), 32'(k < TOT));
            check("t2_in_ready", 32'(in_ready), 32'((k % TOT) == TOT - 1));
            @(negedge clk);
            if (k == TOT - 1) in_valid = 1'b0;
        end
        check("t2_idle", 32'(out_valid), 32'(0));
        check("t2_frames", 32'(frame_cnt), 32'(2));

        // Backpressure pattern 1,0,0,1.
        do_reset();
        w = 96'hA5A5_0F0F_1234_8001_00FF_C3C3;
        recv_word(w, 1'b0, 4'b1001, "t3", ld);
        check("t3_frames", 32'(frame_cnt), 32'(1));

        // X/Z scrubbing: bits [20:17] X, bit 90 Z, rest 1; X tag.
        wx = '1;
        wx[20:17] = 4'bxxxx;
        wx[90] = 1'bz;
        recv_word(wx, 1'bx, 4'b1111, "t4", ld);
        check("t4_frames", 32'(frame_cnt), 32'(2));

        // Reset in the middle of a word, with a new word held off while busy.
        w = 96'h0005_0004_0003_0002_0001_0000;
        in_data = w; in_tag = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_data = ~w;
        @(negedge clk);
        @(negedge clk);
        check("t5_beat2", 32'(out_data), 32'h0002);
        check("t5_busy_not_ready", 32'(in_ready), 32'(0));
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'(0));
        check("t5_rst_data", 32'(out_data), 32'(0));
        check("t5_rst_busy", 32'(busy), 32'(0));
        check("t5_rst_frames", 32'(frame_cnt), 32'(0));
        check("t5_rst_in_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        recv_word(w, 1'b1, 4'b1111, "t5", ld);
        check("t5_frames", 32'(frame_cnt), 32'(1));

`ifdef G_WORD_SERIALIZER_PARITY_EN
        // Parity beat over one-hot beats with tag=1.
        do_reset();
        w = 96'h0020_0010_0008_0004_0002_0001;
        recv_word(w, 1'b1, 4'b1111, "t6", ld);
        check("t6_parity", 32'(ld), 32'h003E);
`endif

        // 256 streamed words: frame_cnt wraps to 0, no bubbles.
        do_reset();
        in_data = 96'h0000_1111_2222_3333_4444_5555; in_tag = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        lasts = 0; vcyc = 0;
        for (int c = 0; c < 4000 && lasts < 256; c++) begin
            @(negedge clk);
            if (out_valid) vcyc++;
            if (out_valid && out_last) begin
                lasts++;
                if (lasts == 256) begin
                    in_valid = 1'b0;
                    check("t7_pre_wrap", 32'(frame_cnt), 32'(255));
                end
            end
        end
        check("t7_words", 32'(lasts), 32'(256));
        check("t7_no_bubble", 32'(vcyc), 32'(256 * TOT));
        @(negedge clk);
        check("t7_wrap", 32'(frame_cnt), 32'(0));
        check("t7_idle", 32'(busy), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
